// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Single-outstanding instruction fetch unit with redirect/drain
//            handling. Optional perf counters under FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] kill_cnt
`endif
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] pc_plus4;
    logic        req_raw;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'd0;
            out_instr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   state_d = redirect_valid ? S_REQ : S_WAIT;
            S_WAIT: begin
                if (redirect_valid)
                    state_d = imem_rvalid ? S_REQ : S_DRAIN;
                else if (imem_rvalid)
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (redirect_valid)
                    state_d = S_REQ;
                else if (out_ready)
                    state_d = S_WAIT;
            end
            S_DRAIN: if (imem_rvalid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        // A redirect always wins the pc, whatever state the fetch is in.
        if (redirect_valid)
            pc_d = redirect_pc;
        case (state_q)
            S_REQ: begin
                if (redirect_valid)
                    out_valid_d = 1'b0;
            end
            S_WAIT: begin
                if (imem_rvalid && !redirect_valid) begin
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_plus4;
                    pc_d        = pc_plus4;
                    out_valid_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || out_ready)
                    out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_raw = 1'b0;
        case (state_q)
            S_REQ:   req_raw = !redirect_valid;
            S_HOLD:  req_raw = !redirect_valid && out_ready;
            default: req_raw = 1'b0;
        endcase
        // Qualified by rst_n so the request drops immediately on reset entry.
        imem_req  = rst_n && req_raw;
        imem_addr = imem_req ? pc_q : 32'd0;
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;
    logic        fetch_inc, kill_inc;

    assign fetch_inc = (state_q == S_HOLD) && out_ready && !redirect_valid;
    assign kill_inc  = ((state_q == S_WAIT)  && imem_rvalid && redirect_valid) ||
                       ((state_q == S_HOLD)  && redirect_valid) ||
                       ((state_q == S_DRAIN) && imem_rvalid);

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_inc};
        kill_cnt_d  = kill_cnt_q + {31'd0, kill_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign kill_cnt  = kill_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Scoreboard bench for instr_fetch with a variable-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_redir = 1'b0;
    logic [31:0] w_redir_pc = 32'd0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, kill_cnt, w_fetch_cnt, w_kill_cnt;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] exp_req_q[$];
    logic [63:0] exp_out_q[$];
    logic [31:0] mon_req_e;
    logic [63:0] mon_out_e;

    int          mem_lat = 1;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h2008_0005;
    endfunction

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .kill_cnt(kill_cnt)
`endif
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .out_valid(w_valid), .out_ready(w_ready),
        .out_pc(w_pc), .out_instr(w_instr),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(w_fetch_cnt), .kill_cnt(w_kill_cnt)
`endif
    );

    // Memory for the main DUT: responds mem_lat cycles after the request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_busy    <= 1'b0;
            mem_cnt     <= 0;
            mem_addr    <= 32'd0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'd0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_req) begin
                if (mem_lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= instr_of(imem_addr);
                end else begin
                    mem_busy <= 1'b1;
                    mem_cnt  <= mem_lat - 1;
                    mem_addr <= imem_addr;
                end
            end else if (mem_busy) begin
                if (mem_cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= instr_of(mem_addr);
                    mem_busy    <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rvalid <= 1'b0;
            w_rdata  <= 32'd0;
        end else begin
            w_rvalid <= w_req;
            w_rdata  <= instr_of(w_addr);
        end
    end

    // Scoreboard monitor: requests and completed transfers, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && imem_req) begin
            total++;
            if (exp_req_q.size() == 0) begin
                bad++;
                $display("FAIL req_unexpected: imem_addr=%h, none expected", imem_addr);
            end else begin
                mon_req_e = exp_req_q.pop_front();
                if (imem_addr !== mon_req_e) begin
                    bad++;
                    $display("FAIL req_addr: got %h expected %h", imem_addr, mon_req_e);
                end
            end
        end
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            total++;
            if (exp_out_q.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected: pc=%h instr=%h", out_pc, out_instr);
            end else begin
                mon_out_e = exp_out_q.pop_front();
                if ({out_pc, out_instr} !== mon_out_e) begin
                    bad++;
                    $display("FAIL xfer: got pc=%h instr=%h expected pc=%h instr=%h",
                             out_pc, out_instr, mon_out_e[63:32], mon_out_e[31:0]);
                end
            end
        end
    end

    task automatic apply_reset(input logic rdy, input int lat);
        @(posedge clk);
        #2;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = rdy;
        mem_lat        = lat;
        exp_req_q.delete();
        exp_out_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL rst_pc: got %h expected 0", out_pc); end
        total++; if (out_instr !== 32'd0) begin bad++; $display("FAIL rst_instr: got %h expected 0", out_instr); end
        total++; if (w_addr !== 32'd0) begin bad++; $display("FAIL rst_wrap_addr: got %h expected 0", w_addr); end
`ifdef FETCH_PERF_CNT_EN
        total++; if ({fetch_cnt, kill_cnt} !== 64'd0) begin bad++; $display("FAIL rst_cnt: got %h/%h expected 0/0", fetch_cnt, kill_cnt); end
`endif
    endtask

    task automatic test_stream();
        logic exp_v;
        apply_reset(1'b1, 1);
        exp_req_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_out_q = '{{32'h4, instr_of(32'h0)}, {32'h8, instr_of(32'h4)}, {32'hC, instr_of(32'h8)}};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); #1;
            exp_v = (k >= 2) && (k % 2 == 0);
            total++;
            if (out_valid !== exp_v) begin
                bad++;
                $display("FAIL stream_valid c%0d: got %b expected %b", k, out_valid, exp_v);
            end
        end
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (exp_req_q.size() != 0 || exp_out_q.size() != 0) begin
            bad++;
            $display("FAIL stream_left: req=%0d out=%0d expected 0/0", exp_req_q.size(), exp_out_q.size());
        end
    endtask

    task automatic test_hold();
        apply_reset(1'b0, 1);
        exp_req_q = '{32'h0, 32'h4};
        exp_out_q = '{{32'h4, 32'h2008_0005}};
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            total++;
            if ({out_valid, out_pc, out_instr, imem_req} !== {1'b1, 32'h4, 32'h2008_0005, 1'b0}) begin
                bad++;
                $display("FAIL hold c%0d: got v=%b pc=%h i=%h req=%b expected v=1 pc=4 i=20080005 req=0",
                         k, out_valid, out_pc, out_instr, imem_req);
            end
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (exp_req_q.size() != 0 || exp_out_q.size() != 0) begin
            bad++;
            $display("FAIL hold_left: req=%0d out=%0d expected 0/0", exp_req_q.size(), exp_out_q.size());
        end
    endtask

    task automatic test_redirect_wait();
        logic seen;
        apply_reset(1'b1, 3);
        exp_req_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
        exp_out_q = '{{32'h4, instr_of(32'h0)}, {32'h8, instr_of(32'h4)}, {32'h104, instr_of(32'h100)}};
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk); #1;
            if (imem_req && imem_addr == 32'h8) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rdw_timeout: got no request to 8, expected one"); end
        @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(posedge clk); #1; redirect_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); #1;
            if (imem_req) seen = 1'b1;
            else begin
                total++;
                if (out_valid !== 1'b0) begin bad++; $display("FAIL rdw_stale: got out_valid=%b expected 0", out_valid); end
            end
        end
        for (int k = 0; k < 40 && exp_out_q.size() != 0; k++) begin @(negedge clk); #1; end
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        total++; if (kill_cnt !== 32'd1) begin bad++; $display("FAIL rdw_kill: got %0d expected 1", kill_cnt); end
        total++; if (fetch_cnt !== 32'd3) begin bad++; $display("FAIL rdw_fetch: got %0d expected 3", fetch_cnt); end
`endif
        total++;
        if (exp_req_q.size() != 0 || exp_out_q.size() != 0) begin
            bad++;
            $display("FAIL rdw_left: req=%0d out=%0d expected 0/0", exp_req_q.size(), exp_out_q.size());
        end
    endtask

    task automatic test_redirect_rvalid();
        apply_reset(1'b1, 1);
        exp_req_q = '{32'h0, 32'h40, 32'h44};
        exp_out_q = '{{32'h44, instr_of(32'h40)}};
        @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(posedge clk); #1; redirect_valid = 1'b0;
        @(negedge clk); #1;
        total++;
        if ({out_valid, imem_req} !== 2'b01) begin
            bad++;
            $display("FAIL rdr_after: got v=%b req=%b expected v=0 req=1", out_valid, imem_req);
        end
        for (int k = 0; k < 40 && exp_out_q.size() != 0; k++) begin @(negedge clk); #1; end
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        total++; if (kill_cnt !== 32'd1) begin bad++; $display("FAIL rdr_kill: got %0d expected 1", kill_cnt); end
`endif
        total++;
        if (exp_req_q.size() != 0 || exp_out_q.size() != 0) begin
            bad++;
            $display("FAIL rdr_left: req=%0d out=%0d expected 0/0", exp_req_q.size(), exp_out_q.size());
        end
    endtask

    task automatic test_redirect_hold();
        apply_reset(1'b1, 1);
        exp_req_q = '{32'h0, 32'h80, 32'h84};
        exp_out_q = '{{32'h84, instr_of(32'h80)}};
        @(posedge clk); #1;
        @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(negedge clk); #1;
        total++;
        if ({out_valid, imem_req} !== 2'b10) begin
            bad++;
            $display("FAIL rdh_cycle: got v=%b req=%b expected v=1 req=0", out_valid, imem_req);
        end
        @(posedge clk); #1; redirect_valid = 1'b0;
        @(negedge clk); #1;
        total++;
        if ({out_valid, imem_req} !== 2'b01) begin
            bad++;
            $display("FAIL rdh_after: got v=%b req=%b expected v=0 req=1", out_valid, imem_req);
        end
        for (int k = 0; k < 40 && exp_out_q.size() != 0; k++) begin @(negedge clk); #1; end
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        total++; if ({fetch_cnt, kill_cnt} !== {32'd1, 32'd1}) begin bad++; $display("FAIL rdh_cnt: got %0d/%0d expected 1/1", fetch_cnt, kill_cnt); end
`endif
        total++;
        if (exp_req_q.size() != 0 || exp_out_q.size() != 0) begin
            bad++;
            $display("FAIL rdh_left: req=%0d out=%0d expected 0/0", exp_req_q.size(), exp_out_q.size());
        end
    endtask

    task automatic test_wrap();
        apply_reset(1'b0, 1);
        exp_req_q = '{32'h0};
        @(negedge clk); #1;
        total++;
        if ({w_req, w_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            bad++;
            $display("FAIL wrap_first: got req=%b addr=%h expected req=1 addr=fffffffc", w_req, w_addr);
        end
        @(negedge clk);
        @(negedge clk); #1;
        total++;
        if ({w_valid, w_pc, w_instr} !== {1'b1, 32'h0, 32'hDFF7_FFF9}) begin
            bad++;
            $display("FAIL wrap_out: got v=%b pc=%h i=%h expected v=1 pc=0 i=dff7fff9", w_valid, w_pc, w_instr);
        end
        total++;
        if ({w_req, w_addr} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL wrap_next: got req=%b addr=%h expected req=1 addr=0", w_req, w_addr);
        end
    endtask

    task automatic test_async_reset();
        logic seen;
        apply_reset(1'b1, 3);
        exp_req_q = '{32'h0, 32'h4};
        exp_out_q = '{{32'h4, instr_of(32'h0)}};
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk); #1;
            if (imem_req && imem_addr == 32'h4) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL ar_timeout: got no request to 4, expected one"); end
        @(posedge clk); #3;
        out_ready = 1'b0;
        total++;
        if (out_pc !== 32'h4) begin bad++; $display("FAIL ar_pre: got out_pc=%h expected 4", out_pc); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, out_valid, out_pc, out_instr} !== 98'd0) begin
            bad++;
            $display("FAIL ar_zero: got req=%b addr=%h v=%b pc=%h i=%h expected all 0",
                     imem_req, imem_addr, out_valid, out_pc, out_instr);
        end
        exp_req_q = '{32'h0};
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL ar_restart: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
        end
        repeat (6) @(negedge clk);
        total++;
        if (exp_req_q.size() != 0 || exp_out_q.size() != 0) begin
            bad++;
            $display("FAIL ar_left: req=%0d out=%0d expected 0/0", exp_req_q.size(), exp_out_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_hold();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  in  1  rising-edge clock; the only clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 imem_req  out  1  fetch request; memory accepts it unconditionally in the cycle it is high.
REQ-005 imem_addr  out  32  word address for imem_req.
REQ-006 imem_rvalid  in  1  response strobe, one pulse per request, arriving one or more cycles after imem_req.
REQ-007 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-008 out_valid  out  1  out_pc/out_instr hold a fetched instruction for the IF/ID register.
REQ-009 out_ready  in  1  IF/ID register accepts this cycle; transfer = out_valid & out_ready.
REQ-010 out_pc  out  32  PC+4 of the presented instruction.
REQ-011 out_instr  out  32  presented instruction word.
REQ-012 redirect_valid  in  1  branch/jump redirect pulse; highest priority.
REQ-013 redirect_pc  in  32  new fetch address, valid with redirect_valid.

Function
REQ-014 The block SHALL hold a 32-bit pc register and a 2-bit state: S_REQ, S_WAIT, S_HOLD, S_DRAIN.
REQ-015 The block SHALL keep at most one request outstanding.
REQ-016 S_REQ: imem_req=1, imem_addr=pc; next state S_WAIT.
REQ-017 S_WAIT with imem_rvalid: out_instr<=imem_rdata; out_pc<=pc+4; pc<=pc+4; out_valid<=1; next state S_HOLD.
REQ-018 S_HOLD with out_ready=1: imem_req=1 and imem_addr=pc in the same cycle; out_valid<=0; next state S_WAIT.
REQ-019 S_HOLD with out_ready=0: out_valid, out_pc and out_instr SHALL stay stable; no request is issued.
REQ-020 Redirect in S_REQ or S_HOLD: pc<=redirect_pc; out_valid<=0; no imem_req that cycle; next state S_REQ. A concurrent out_ready does not complete a transfer.
REQ-021 Redirect in S_WAIT with no imem_rvalid: pc<=redirect_pc; next state S_DRAIN.
REQ-022 Redirect in S_WAIT together with imem_rvalid: rdata discarded; pc<=redirect_pc; out_valid stays 0; next state S_REQ.
REQ-023 S_DRAIN: the next imem_rvalid SHALL be discarded, then next state S_REQ. A further redirect in S_DRAIN only updates pc.
REQ-024 imem_rvalid in S_REQ or S_HOLD SHALL be ignored.
REQ-025 pc+4 SHALL wrap modulo 2^32; 32'hFFFF_FFFC produces 32'h0000_0000.
REQ-026 Throughput SHALL be one instruction per 2 cycles with single-cycle memory and out_ready held high.

Reset
REQ-027 While rst_n=0, immediately and independent of clk: pc=RESET_PC; state=S_REQ; out_valid=0; out_pc=0; out_instr=0; imem_req=0; imem_addr=0; performance counters=0.
REQ-028 The first imem_req SHALL be issued in the first cycle after rst_n rises, with imem_addr=RESET_PC.
REQ-029 Reset during S_WAIT or S_DRAIN SHALL abandon the outstanding request; the memory is reset in the same domain.

Configuration
REQ-030 With FETCH_PERF_CNT_EN defined, the block SHALL add two 32-bit output ports, both wrapping:
- fetch_cnt: count of completed transfers.
- kill_cnt: count of discarded responses and discarded held instructions.
REQ-031 Without FETCH_PERF_CNT_EN, these ports and their logic SHALL NOT exist; all other behaviour is identical.

Verification
REQ-032 Reset release; 1-cycle memory; out_ready=1 -> imem_addr sequence 0,4,8; out_pc 4,8,12; out_valid high every second cycle.
REQ-033 Instruction 32'h2008_0005 at 0; out_ready=0 for 5 cycles -> out_valid, out_pc=4 and out_instr stable; no imem_req until out_ready=1.
REQ-034 Redirect to 32'h0000_0100 while S_WAIT on address 8, 3-cycle memory latency:
- stale response dropped, out_valid stays 0.
- next imem_addr=32'h100; out_pc=32'h104.
- kill_cnt=1 when FETCH_PERF_CNT_EN is defined.
REQ-035 Redirect to 32'h40 in the same cycle as imem_rvalid -> data discarded; next imem_addr=32'h40.
REQ-036 RESET_PC=32'hFFFF_FFFC -> first out_pc=32'h0000_0000; next imem_addr=0.
REQ-037 rst_n asserted mid S_WAIT -> outputs zero without a clock edge; after release, imem_addr=RESET_PC.
